fishing_level_ctrl: RTL and testbench

//  Parametrised game-state controller for the VGA fishing game: N fish levels, per-level depth/size,

---
 rtl/fishing_pkg.sv | 46 ++++
 rtl/fish_x_mover.sv | 35 +++
 rtl/fishing_level_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fishing_level_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fishing_pkg.sv
// Shared state encoding, fish x-register opcodes and per-level fish geometry
// for the fishing game controller.
package fishing_pkg;

  typedef enum logic [2:0] {
    ST_FISH   = 3'd0,
    ST_REEL   = 3'd1,
    ST_ESCAPE = 3'd2,
    ST_LANDED = 3'd3,
    ST_WIN    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FX_HOLD    = 2'd0,
    FX_STEP    = 2'd1,
    FX_RESPAWN = 2'd2,
    FX_ROD     = 2'd3
  } fx_op_t;

  localparam int DEPTH_TOP  = 470;
  localparam int DEPTH_STEP = 90;
  // Levels past 4 would dive above the catch line; hold them just below it.
  localparam int DEPTH_MIN  = 110;

  function automatic logic [9:0] fish_depth(input logic [2:0] l);
    int d;
    d = DEPTH_TOP - DEPTH_STEP * int'(l);
    if (d < DEPTH_MIN) d = DEPTH_MIN;
    return 10'(d);
  endfunction

  function automatic logic [6:0] fish_len(input logic [2:0] l);
    logic [6:0] v;
    v = 7'd60 >> l;
    if (v < 7'd8) v = 7'd8;
    return v;
  endfunction

  function automatic logic [3:0] fish_hh(input logic [2:0] l);
    int h;
    h = 10 - 2 * int'(l);
    if (h < 2) h = 2;
    return 4'(h);
  endfunction

endpackage

// File: rtl/fish_x_mover.sv
// Fish left-edge register: swims left with wrap, respawns at the right edge,
// or follows the rod while hooked.
module fish_x_mover
  import fishing_pkg::*;
#(
  parameter int X_MIN      = 144,
  parameter int X_MAX      = 798,
  parameter int FISH_SPEED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  fx_op_t     op,
  input  logic [9:0] rod_x,
  output logic [9:0] fish_x
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fish_x <= 10'(X_MAX);
    end else begin
      case (op)
        FX_STEP: begin
          if (fish_x <= 10'(X_MIN) || fish_x < 10'(FISH_SPEED))
            fish_x <= 10'(X_MAX);
          else
            fish_x <= fish_x - 10'(FISH_SPEED);
        end
        FX_RESPAWN: fish_x <= 10'(X_MAX);
        FX_ROD:     fish_x <= rod_x;
        default:    fish_x <= fish_x;
      endcase
    end
  end

endmodule

// File: rtl/fishing_level_ctrl.sv
// Game-tick controller for the fishing game: rod/line/fish motion, hook, reel,
// escape and landing sequencing across levels, plus score and miss counters.
module fishing_level_ctrl
  import fishing_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int REEL_W       = 14,
  parameter int X_MIN        = 144,
  parameter int X_MAX        = 798,
  parameter int ROD_X_MIN    = 312,
  parameter int SURFACE_Y    = 155,
  parameter int CATCH_Y      = 106,
  parameter int FISH_SPEED   = 2,
  parameter int ROD_SPEED    = 3,
  parameter int SINK_SPEED   = 4,
  parameter int REEL_SPEED   = 2,
  parameter int ESCAPE_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              left,
  input  logic              right,
  input  logic [REEL_W-1:0] reel,
  output logic [9:0]        rod_x,
  output logic [9:0]        line_y,
  output logic [9:0]        fish_x,
  output logic [9:0]        fish_y,
  output logic [6:0]        fish_len,
  output logic [3:0]        fish_hh,
  output logic [2:0]        level,
  output logic [2:0]        state,
  output logic [7:0]        score,
  output logic [7:0]        misses,
  output logic              win
);

  localparam int         IDLE_W     = $clog2(ESCAPE_TICKS + 1);
  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);

  state_t            state_q, state_d;
  fx_op_t            fx_op;
  logic [2:0]        level_d;
  logic [9:0]        rod_d, line_d, fish_y_d;
  logic [7:0]        score_d, misses_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [10:0]       sink_sum;
  logic [9:0]        y_gap, hook_hi;
  logic              hook;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [9:0] sub_floor(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a - b : 10'd0;
  endfunction

  fish_x_mover #(
    .X_MIN     (X_MIN),
    .X_MAX     (X_MAX),
    .FISH_SPEED(FISH_SPEED)
  ) u_fish_x (
    .clk   (clk),
    .rst   (rst),
    .op    (fx_op),
    .rod_x (rod_x),
    .fish_x(fish_x)
  );

  assign fish_len = fishing_pkg::fish_len(level);
  assign fish_hh  = fishing_pkg::fish_hh(level);
  assign state    = state_q;
  assign win      = (state_q == ST_WIN);

  // Hook window: rod over the front quarter of the fish, line tip within half-height.
  assign sink_sum = {1'b0, line_y} + 11'(SINK_SPEED);
  assign y_gap    = (line_y >= fish_y) ? line_y - fish_y : fish_y - line_y;
  assign hook_hi  = fish_x + {5'd0, fish_len[6:2]};
  assign hook     = up && (rod_x >= fish_x) && (rod_x <= hook_hi) && (y_gap <= {6'd0, fish_hh});

  always_comb begin
    state_d  = state_q;
    fx_op    = FX_HOLD;
    level_d  = level;
    rod_d    = rod_x;
    line_d   = line_y;
    fish_y_d = fish_y;
    score_d  = score;
    misses_d = misses;
    idle_d   = idle_q;
    case (state_q)
      ST_FISH: begin
        fx_op = FX_STEP;
        if (right) begin
          if (rod_x <= 10'(X_MAX)) rod_d = rod_x + 10'(ROD_SPEED);
        end else if (left) begin
          if (rod_x >= 10'(ROD_X_MIN)) rod_d = sub_floor(rod_x, 10'(ROD_SPEED));
        end
        line_d = (sink_sum <= {1'b0, fish_y}) ? sink_sum[9:0] : fish_y;
        if (hook) begin
          state_d = ST_REEL;
          idle_d  = '0;
        end
      end
      ST_REEL: begin
        fx_op = FX_ROD;
        if (fish_y < 10'(CATCH_Y)) begin
          state_d = ST_LANDED;
        end else if (reel != '0) begin
          fish_y_d = sub_floor(fish_y, 10'(REEL_SPEED));
          line_d   = sub_floor(line_y, 10'(REEL_SPEED));
          idle_d   = '0;
        end else if (idle_q == IDLE_W'(ESCAPE_TICKS - 1)) begin
          state_d = ST_ESCAPE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_ESCAPE: begin
        misses_d = sat_add8(misses, 8'd1);
        fx_op    = FX_RESPAWN;
        fish_y_d = fish_depth(level);
        state_d  = ST_FISH;
      end
      ST_LANDED: begin
        score_d = sat_add8(score, {5'd0, level} + 8'd1);
        if (level < LAST_LEVEL) begin
          level_d  = level + 3'd1;
          fx_op    = FX_RESPAWN;
          fish_y_d = fish_depth(level + 3'd1);
          state_d  = ST_FISH;
        end else begin
          state_d = ST_WIN;
        end
      end
      ST_WIN: begin
        if (left || right) begin
          state_d  = ST_FISH;
          level_d  = 3'd0;
          line_d   = 10'(SURFACE_Y);
          fx_op    = FX_RESPAWN;
          fish_y_d = fish_depth(3'd0);
          score_d  = 8'd0;
          misses_d = 8'd0;
        end
      end
      default: state_d = ST_FISH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FISH;
      level   <= 3'd0;
      rod_x   <= 10'd450;
      line_y  <= 10'(SURFACE_Y);
      fish_y  <= fish_depth(3'd0);
      score   <= 8'd0;
      misses  <= 8'd0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      level   <= level_d;
      rod_x   <= rod_d;
      line_y  <= line_d;
      fish_y  <= fish_y_d;
      score   <= score_d;
      misses  <= misses_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_fishing_level_ctrl.sv
// Directed bench for fishing_level_ctrl: reset, sink/wrap, hook/land, escape,
// win/restart, rod limits and asynchronous reset while reeling.
module tb_fishing_level_ctrl;

  localparam logic [2:0] S_FISH = 3'd0, S_REEL = 3'd1, S_ESCAPE = 3'd2,
                         S_LANDED = 3'd3, S_WIN = 3'd4;

  logic        clk = 1'b0;
  logic        rst, up, left, right;
  logic [13:0] reel;
  logic [9:0]  rod_x, line_y, fish_x, fish_y;
  logic [6:0]  fish_len;
  logic [3:0]  fish_hh;
  logic [2:0]  level, state;
  logic [7:0]  score, misses;
  logic        win;

  int tests = 0;
  int fails = 0;

  fishing_level_ctrl dut (
    .clk(clk), .rst(rst), .up(up), .left(left), .right(right), .reel(reel),
    .rod_x(rod_x), .line_y(line_y), .fish_x(fish_x), .fish_y(fish_y),
    .fish_len(fish_len), .fish_hh(fish_hh), .level(level), .state(state),
    .score(score), .misses(misses), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hook_land(input logic [9:0] tgt, input bit land);
    int n;
    n = 0;
    while (!(fish_x == tgt && line_y == fish_y && state == S_FISH) && n < 2000) begin
      tick();
      n++;
    end
    chk("hook_wait", 32'(n < 2000), 32'd1);
    up = 1'b1;
    tick();
    up = 1'b0;
    chk("hook_state", 32'(state), 32'(S_REEL));
    if (land) begin
      reel = 14'd1;
      n = 0;
      while (state != S_LANDED && n < 600) begin
        tick();
        n++;
      end
      reel = 14'd0;
      chk("land_wait", 32'(n < 600), 32'd1);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; up = 1'b0; left = 1'b0; right = 1'b0; reel = 14'd0;
    #2 rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(S_FISH));
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rod", 32'(rod_x), 32'd450);
    chk("rst_line", 32'(line_y), 32'd155);
    chk("rst_fx", 32'(fish_x), 32'd798);
    chk("rst_fy", 32'(fish_y), 32'd470);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_miss", 32'(misses), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_len", 32'(fish_len), 32'd60);
    chk("rst_hh", 32'(fish_hh), 32'd10);
    @(posedge clk);
    #1 rst = 1'b1;

    // Sink and wrap at level 0, with one rod step right.
    right = 1'b1;
    tick();
    right = 1'b0;
    chk("rod_right", 32'(rod_x), 32'd453);
    repeat (77) tick();
    chk("sink_467", 32'(line_y), 32'd467);
    chk("fx_642", 32'(fish_x), 32'd642);
    tick();
    chk("sink_clamp", 32'(line_y), 32'd470);
    tick();
    chk("sink_hold", 32'(line_y), 32'd470);
    repeat (246) tick();
    chk("fx_146", 32'(fish_x), 32'd146);
    tick();
    chk("fx_144", 32'(fish_x), 32'd144);
    tick();
    chk("fx_wrap", 32'(fish_x), 32'd798);

    // Hook with rod at fish_x+5 and land level 0.
    repeat (175) tick();
    chk("fx_448", 32'(fish_x), 32'd448);
    up = 1'b1;
    tick();
    up = 1'b0;
    chk("hook0", 32'(state), 32'(S_REEL));
    chk("hook0_fx", 32'(fish_x), 32'd446);
    reel = 14'd1;
    repeat (183) tick();
    chk("reel_state", 32'(state), 32'(S_REEL));
    chk("reel_fy", 32'(fish_y), 32'd104);
    chk("reel_line", 32'(line_y), 32'd104);
    chk("reel_fx", 32'(fish_x), 32'd453);
    tick();
    chk("landed", 32'(state), 32'(S_LANDED));
    tick();
    reel = 14'd0;
    chk("l1_state", 32'(state), 32'(S_FISH));
    chk("l1_score", 32'(score), 32'd1);
    chk("l1_level", 32'(level), 32'd1);
    chk("l1_fy", 32'(fish_y), 32'd380);
    chk("l1_fx", 32'(fish_x), 32'd798);
    chk("l1_len", 32'(fish_len), 32'd30);
    chk("l1_hh", 32'(fish_hh), 32'd8);

    // Hook at level 1 then leave the reel idle until the fish escapes.
    repeat (175) tick();
    chk("l1_line", 32'(line_y), 32'd380);
    up = 1'b1;
    tick();
    up = 1'b0;
    chk("hook1", 32'(state), 32'(S_REEL));
    repeat (63) tick();
    chk("idle63", 32'(state), 32'(S_REEL));
    tick();
    chk("escape", 32'(state), 32'(S_ESCAPE));
    tick();
    chk("esc_state", 32'(state), 32'(S_FISH));
    chk("esc_miss", 32'(misses), 32'd1);
    chk("esc_fx", 32'(fish_x), 32'd798);
    chk("esc_fy", 32'(fish_y), 32'd380);
    chk("esc_line", 32'(line_y), 32'd380);

    // Land levels 1..3 to reach WIN.
    hook_land(10'd452, 1'b1);
    chk("l2_level", 32'(level), 32'd2);
    chk("l2_score", 32'(score), 32'd3);
    chk("l2_fy", 32'(fish_y), 32'd290);
    chk("l2_len", 32'(fish_len), 32'd15);
    chk("l2_hh", 32'(fish_hh), 32'd6);
    hook_land(10'd452, 1'b1);
    chk("l3_level", 32'(level), 32'd3);
    chk("l3_score", 32'(score), 32'd6);
    chk("l3_fy", 32'(fish_y), 32'd200);
    chk("l3_len", 32'(fish_len), 32'd8);
    chk("l3_hh", 32'(fish_hh), 32'd4);
    hook_land(10'd452, 1'b1);
    chk("win_state", 32'(state), 32'(S_WIN));
    chk("win_flag", 32'(win), 32'd1);
    chk("win_score", 32'(score), 32'd10);
    chk("win_miss", 32'(misses), 32'd1);
    chk("win_fx", 32'(fish_x), 32'd453);
    tick();
    chk("win_frozen", 32'(fish_x), 32'd453);
    chk("win_hold", 32'(state), 32'(S_WIN));

    // Restart from WIN keeps the rod position.
    right = 1'b1;
    tick();
    right = 1'b0;
    chk("rs_state", 32'(state), 32'(S_FISH));
    chk("rs_level", 32'(level), 32'd0);
    chk("rs_score", 32'(score), 32'd0);
    chk("rs_miss", 32'(misses), 32'd0);
    chk("rs_win", 32'(win), 32'd0);
    chk("rs_rod", 32'(rod_x), 32'd453);
    chk("rs_fx", 32'(fish_x), 32'd798);
    chk("rs_fy", 32'(fish_y), 32'd470);
    chk("rs_line", 32'(line_y), 32'd155);

    // Rod left limit and right priority.
    left = 1'b1;
    repeat (47) tick();
    chk("rod_312", 32'(rod_x), 32'd312);
    tick();
    chk("rod_309", 32'(rod_x), 32'd309);
    tick();
    chk("rod_stop", 32'(rod_x), 32'd309);
    right = 1'b1;
    tick();
    left = 1'b0; right = 1'b0;
    chk("rod_prio", 32'(rod_x), 32'd312);

    // Asynchronous reset while reeling.
    hook_land(10'd312, 1'b0);
    reel = 14'h2000;
    repeat (5) tick();
    chk("mid_reel", 32'(state), 32'(S_REEL));
    chk("mid_fy", 32'(fish_y), 32'd460);
    rst = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'(S_FISH));
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_score", 32'(score), 32'd0);
    chk("ar_line", 32'(line_y), 32'd155);
    chk("ar_fx", 32'(fish_x), 32'd798);
    chk("ar_rod", 32'(rod_x), 32'd450);
    reel = 14'd0;
    @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
